uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Round-robin scheduler sharing one UART transmit engine among NUM_REQ byte producers.
//  Each requester presents a byte with valid/ack.
//  The arbiter grants one requester at a time, latches its byte and issues a start pulse to the engine.
//  It then tracks the engine's busy flag until the frame completes.
//  It sits between the protocol/command clients and the single UART TX serialiser on the board pin.
// PARAMETERS
//  NUM_REQ     4        number of requesters, 2..8
//  DATA_WIDTH  8        byte width, must equal the TX engine data width
//  ID_MARK     8'hA0    source-ID header base (UART_ARB_SRCID_EN only); low 3 bits must be 0
// PORTS
//  clk         in   1                    system clock
//  rst         in   1                    synchronous reset, active-high
//  req_valid   in   NUM_REQ              per-requester byte valid; held until its req_ack
//  req_data    in   NUM_REQ*DATA_WIDTH   requester i byte at [i*DATA_WIDTH +: DATA_WIDTH]
//  req_ack     out  NUM_REQ              one-cycle, one-hot acknowledge: byte consumed
//  tx_start    out  1                    one-cycle start pulse to TX engine
//  tx_data     out  DATA_WIDTH           byte to TX engine; stable from tx_start until engine done
//  tx_busy     in   1                    TX engine frame in progress
//  grant_id    out  $clog2(NUM_REQ)      index of current/last granted requester
//  active      out  1                    1 whenever state != IDLE
// BEHAVIOUR
//  Reset values: req_ack=0, tx_start=0, tx_data=0, grant_id=0, active=0, state=IDLE.
//  Reset value of the rr pointer: last=NUM_REQ-1, so requester 0 wins first.
//  States: IDLE -> ISSUE -> WAIT_ACC -> WAIT_DONE -> IDLE.
//  IDLE: arbitrate when |req_valid && !tx_busy; otherwise hold.
//   Search order: last+1, last+2, ... mod NUM_REQ.
//   Winner g: latch req_data[g], grant_id<=g, last<=g, go to ISSUE.
//  req_ack[g]=1 for exactly the cycle after the arbitration edge; the client may change valid/data from then.
//  ISSUE: tx_start=1 for one cycle, tx_data=latched byte, go to WAIT_ACC.
//  WAIT_ACC: wait for tx_busy=1, then go to WAIT_DONE. There is no timeout; wait is indefinite.
//  WAIT_DONE: wait for tx_busy=0, then go to IDLE.
//   The earliest next arbitration is the following cycle.
//   Worst-case requester wait is NUM_REQ-1 frames.
//  Latency: arbitration edge -> tx_start is 1 cycle. Minimum issue-to-issue gap is engine frame time + 3 cycles.
//  A request deasserted before arbitration is simply not considered.
//  Deasserting valid after arbitration but before ack is illegal; the latched byte is still sent.
//  Simultaneous valid from all requesters gives strict rotation 0,1,..,NUM_REQ-1,0.
//  Pointer wrap is modulo NUM_REQ, including non-power-of-2 values.
//  tx_busy=1 while in IDLE blocks arbitration (foreign or unfinished frame).
//  Reset mid-operation:
//   Next cycle all outputs are at reset values, state=IDLE and the rr pointer is reset.
//   A latched byte is discarded and no ack is given for it if still pending.
//   A frame already inside the engine is not aborted by this block.
//  Only one req_ack bit is ever set. tx_start never asserts outside ISSUE.
// CONFIGURATION
//  Macro UART_ARB_SRCID_EN.
//  Defined: each grant sends two frames.
//   First the header ID_MARK | grant_id, then the data byte.
//   Each frame runs ISSUE/WAIT_ACC/WAIT_DONE, selected by an internal phase flag.
//   req_ack timing is unchanged (cycle after arbitration).
//   tx_data holds the header until the header frame completes.
//  Undefined: single data frame per grant. The header logic and ID_MARK are unused.
// TESTING
//  TX engine model: tx_busy rises 1 cycle after tx_start and stays high 10 cycles.
//  1. Only req_valid[2]=1, data 0x5A
//     -> req_ack=4'b0100 for one cycle; one tx_start with tx_data=0x5A; grant_id=2.
//     -> active falls 1 cycle after tx_busy falls.
//  2. All 4 valid continuously, distinct bytes 0x10..0x13
//     -> tx_data sequence 0x10,0x11,0x12,0x13,0x10; exactly one ack per frame.
//  3. req_valid[1]=1 while tx_busy is forced 1 for 20 cycles
//     -> no ack and no tx_start until 1 cycle after tx_busy=0; then grant_id=1.
//  4. rst pulsed during WAIT_DONE of client 2
//     -> next cycle active=0, tx_start=0, grant_id=0.
//     -> with clients 0 and 2 valid, the next grant goes to 0.
//  5. Last grant=1; clients 1 and 3 valid
//     -> grant 3 then 1 (wrap); with NUM_REQ=3 and clients 0,2 valid after last=2 -> grant 0.
//  6. UART_ARB_SRCID_EN defined; client 3 sends 0x11
//     -> two tx_start pulses: tx_data 0xA3 then 0x11; req_ack[3] pulsed once.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin scheduler sharing one UART TX engine among
// NUM_REQ byte producers. Each grant latches the winner's byte, pulses
// o_tx_start and follows i_tx_busy until the frame completes.
// Optional feature macro: UART_ARB_SRCID_EN. When it is defined, every grant
// sends a header frame (ID_MARK | grant id) ahead of the data frame.
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
`ifdef UART_ARB_SRCID_EN
  ,
  parameter logic [DATA_WIDTH-1:0] ID_MARK = 8'hA0
`endif
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]            o_req_ack,
  output logic                          o_tx_start,
  output logic [DATA_WIDTH-1:0]         o_tx_data,
  input  logic                          i_tx_busy,
  output logic [$clog2(NUM_REQ)-1:0]    o_grant_id,
  output logic                          o_active
);

  localparam int IDW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACC,
    S_WAIT_DONE
  } state_t;

  state_t                  r_state;
  logic [IDW-1:0]          r_last;
  logic [NUM_REQ-1:0]      r_reqAck;
  logic                    r_txStart;
  logic [DATA_WIDTH-1:0]   r_txData;
  logic [IDW-1:0]          r_grantId;
  logic                    r_active;
`ifdef UART_ARB_SRCID_EN
  logic [DATA_WIDTH-1:0]   r_dataByte;
  logic                    r_phaseData;
`endif

  logic                    w_found;
  logic [IDW-1:0]          w_winner;
  logic [NUM_REQ-1:0]      w_winOneHot;
  logic [DATA_WIDTH-1:0]   w_winData;
  int                      w_dist;
  int                      w_bestDist;

  // Rotating priority: the valid requester closest after r_last (mod NUM_REQ) wins.
  always_comb begin
    w_found     = 1'b0;
    w_winner    = '0;
    w_winOneHot = '0;
    w_winData   = '0;
    w_dist      = 0;
    w_bestDist  = NUM_REQ;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (i > int'(r_last)) begin
        w_dist = i - int'(r_last) - 1;
      end else begin
        w_dist = i + NUM_REQ - int'(r_last) - 1;
      end
      if (i_req_valid[i] && (w_dist < w_bestDist)) begin
        w_bestDist     = w_dist;
        w_found        = 1'b1;
        w_winner       = IDW'(i);
        w_winOneHot    = '0;
        w_winOneHot[i] = 1'b1;
        w_winData      = i_req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Grant/issue/track state machine; every output is a register updated here.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_last      <= IDW'(NUM_REQ - 1);
      r_reqAck    <= '0;
      r_txStart   <= 1'b0;
      r_txData    <= '0;
      r_grantId   <= '0;
      r_active    <= 1'b0;
`ifdef UART_ARB_SRCID_EN
      r_dataByte  <= '0;
      r_phaseData <= 1'b0;
`endif
    end else begin
      r_reqAck  <= '0;
      r_txStart <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found && !i_tx_busy) begin
            r_reqAck    <= w_winOneHot;
            r_grantId   <= w_winner;
            r_last      <= w_winner;
            r_txStart   <= 1'b1;
            r_active    <= 1'b1;
            r_state     <= S_ISSUE;
`ifdef UART_ARB_SRCID_EN
            r_dataByte  <= w_winData;
            r_txData    <= ID_MARK | DATA_WIDTH'(w_winner);
            r_phaseData <= 1'b0;
`else
            r_txData    <= w_winData;
`endif
          end
        end
        S_ISSUE: begin
          r_state <= S_WAIT_ACC;
        end
        S_WAIT_ACC: begin
          if (i_tx_busy) begin
            r_state <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (!i_tx_busy) begin
`ifdef UART_ARB_SRCID_EN
            if (!r_phaseData) begin
              r_phaseData <= 1'b1;
              r_txData    <= r_dataByte;
              r_txStart   <= 1'b1;
              r_state     <= S_ISSUE;
            end else begin
              r_state  <= S_IDLE;
              r_active <= 1'b0;
            end
`else
            r_state  <= S_IDLE;
            r_active <= 1'b0;
`endif
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_active <= 1'b0;
        end
      endcase
    end
  end

  assign o_req_ack  = r_reqAck;
  assign o_tx_start = r_txStart;
  assign o_tx_data  = r_txData;
  assign o_grant_id = r_grantId;
  assign o_active   = r_active;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed bench for uart_tx_arbiter with NUM_REQ=4 and a
// second NUM_REQ=3 instance for the non-power-of-two pointer wrap.
// Works in both the default build and with UART_ARB_SRCID_EN defined.
module tb_uart_tx_arbiter;

  localparam logic [7:0] ID_MARK = 8'hA0;
`ifdef UART_ARB_SRCID_EN
  localparam bit SRCID = 1'b1;
`else
  localparam bit SRCID = 1'b0;
`endif
  localparam int FRAMES = SRCID ? 2 : 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  reqValid = '0;
  logic [31:0] reqData = '0;
  logic [3:0]  reqAck;
  logic        txStart;
  logic [7:0]  txData;
  logic        txBusy;
  logic [1:0]  grantId;
  logic        active;
  logic        forceBusy = 1'b0;
  logic        busyModel = 1'b0;
  int          busyCnt = 0;

  logic [2:0]  reqValid3 = '0;
  logic [23:0] reqData3 = '0;
  logic [2:0]  reqAck3;
  logic        txStart3;
  logic [7:0]  txData3;
  logic        busyModel3 = 1'b0;
  int          busyCnt3 = 0;
  logic [1:0]  grantId3;
  logic        active3;

  int checks = 0;
  int failures = 0;
  logic [7:0] capQ[$];
  logic [3:0] ackQ[$];

  uart_tx_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(reqValid), .i_req_data(reqData),
    .o_req_ack(reqAck), .o_tx_start(txStart), .o_tx_data(txData),
    .i_tx_busy(txBusy), .o_grant_id(grantId), .o_active(active));

  uart_tx_arbiter #(.NUM_REQ(3), .DATA_WIDTH(8)) dut3 (
    .i_clk(clk), .i_rst(rst), .i_req_valid(reqValid3), .i_req_data(reqData3),
    .o_req_ack(reqAck3), .o_tx_start(txStart3), .o_tx_data(txData3),
    .i_tx_busy(busyModel3), .o_grant_id(grantId3), .o_active(active3));

  always #5 clk = ~clk;

  assign txBusy = busyModel | forceBusy;

  // TX engine stand-in: busy rises the cycle after a start pulse and holds for 10 cycles.
  always @(posedge clk) begin
    if (txStart) begin
      busyModel <= 1'b1;
      busyCnt   <= 10;
    end else if (busyCnt > 0) begin
      busyCnt <= busyCnt - 1;
      if (busyCnt == 1) busyModel <= 1'b0;
    end
  end

  // Same engine stand-in for the three-requester instance.
  always @(posedge clk) begin
    if (txStart3) begin
      busyModel3 <= 1'b1;
      busyCnt3   <= 10;
    end else if (busyCnt3 > 0) begin
      busyCnt3 <= busyCnt3 - 1;
      if (busyCnt3 == 1) busyModel3 <= 1'b0;
    end
  end

  // Record every byte handed to the engine and every acknowledge, mid-cycle.
  always @(negedge clk) begin
    if (txStart) capQ.push_back(txData);
    if (reqAck != 4'b0000) ackQ.push_back(reqAck);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] valid, input logic [31:0] data);
    reqValid = valid;
    reqData  = data;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] firstByte(input int id, input logic [7:0] b);
    return SRCID ? (ID_MARK | 8'(id)) : b;
  endfunction

  task automatic waitAck(input string tag);
    int n = 0;
    while (reqAck === 4'b0000 && n < 300) begin
      step();
      n++;
    end
    checkOutput(tag, 32'(n < 300), 32'd1);
  endtask

  task automatic waitIdle(input string tag);
    int n = 0;
    while (active !== 1'b0 && n < 300) begin
      step();
      n++;
    end
    checkOutput(tag, 32'(n < 300), 32'd1);
  endtask

  task automatic waitAck3(input string tag);
    int n = 0;
    while (reqAck3 === 3'b000 && n < 300) begin
      step();
      n++;
    end
    checkOutput(tag, 32'(n < 300), 32'd1);
  endtask

  task automatic waitIdle3(input string tag);
    int n = 0;
    while (active3 !== 1'b0 && n < 300) begin
      step();
      n++;
    end
    checkOutput(tag, 32'(n < 300), 32'd1);
  endtask

  initial begin
    int n;
    logic p1, p2, bad;
    logic [7:0] expData [5];
    logic [3:0] expAck [5];
    expData = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    expAck  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    $display("[TB] reset values");
    applyStimulus(4'b1111, 32'h13121110);
    step(); step(); step();
    checkOutput("rst_ack", 32'(reqAck), 32'h0);
    checkOutput("rst_start", 32'(txStart), 32'h0);
    checkOutput("rst_data", 32'(txData), 32'h0);
    checkOutput("rst_gid", 32'(grantId), 32'h0);
    checkOutput("rst_active", 32'(active), 32'h0);

    $display("[TB] single requester 2");
    applyStimulus(4'b0100, 32'h005A0000);
    rst = 1'b0;
    capQ.delete();
    ackQ.delete();
    step();
    checkOutput("t1_ack", 32'(reqAck), 32'h4);
    checkOutput("t1_start", 32'(txStart), 32'h1);
    checkOutput("t1_data", 32'(txData), 32'(firstByte(2, 8'h5A)));
    checkOutput("t1_gid", 32'(grantId), 32'h2);
    checkOutput("t1_active", 32'(active), 32'h1);
    applyStimulus(4'b0000, 32'h0);
    step();
    checkOutput("t1_ack_gone", 32'(reqAck), 32'h0);
    checkOutput("t1_start_gone", 32'(txStart), 32'h0);
    n = 1;
    p1 = 1'b0;
    p2 = 1'b0;
    while (active !== 1'b0 && n < 100) begin
      p2 = p1;
      p1 = txBusy;
      step();
      n++;
    end
    checkOutput("t1_active_len", 32'(n), 32'(12 * FRAMES));
    checkOutput("t1_busy_prev", 32'(p1), 32'h0);
    checkOutput("t1_busy_prev2", 32'(p2), 32'h1);
    checkOutput("t1_frames", 32'(capQ.size()), 32'(FRAMES));
    checkOutput("t1_last_byte", 32'(capQ[capQ.size()-1]), 32'h5A);
    checkOutput("t1_acks", 32'(ackQ.size()), 32'd1);

    $display("[TB] all requesters, strict rotation");
    rst = 1'b1;
    step();
    rst = 1'b0;
    capQ.delete();
    ackQ.delete();
    applyStimulus(4'b1111, 32'h13121110);
    n = 0;
    while (ackQ.size() < 5 && n < 500) begin
      step();
      n++;
    end
    checkOutput("t2_five_acks", 32'(n < 500), 32'd1);
    applyStimulus(4'b0000, 32'h0);
    waitIdle("t2_idle");
    checkOutput("t2_ack_count", 32'(ackQ.size()), 32'd5);
    checkOutput("t2_frame_count", 32'(capQ.size()), 32'(5 * FRAMES));
    for (int k = 0; k < 5; k++) begin
      if (ackQ.size() > k) checkOutput($sformatf("t2_ack%0d", k), 32'(ackQ[k]), 32'(expAck[k]));
      if (capQ.size() > k * FRAMES + FRAMES - 1)
        checkOutput($sformatf("t2_data%0d", k), 32'(capQ[k*FRAMES+FRAMES-1]), 32'(expData[k]));
`ifdef UART_ARB_SRCID_EN
      if (capQ.size() > k * 2)
        checkOutput($sformatf("t2_hdr%0d", k), 32'(capQ[k*2]), 32'(ID_MARK | 8'(k % 4)));
`endif
    end

    $display("[TB] busy engine blocks arbitration");
    forceBusy = 1'b1;
    applyStimulus(4'b0010, 32'h00003100);
    bad = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (reqAck !== 4'b0000 || txStart !== 1'b0) bad = 1'b1;
    end
    checkOutput("t3_blocked", 32'(bad), 32'h0);
    forceBusy = 1'b0;
    checkOutput("t3_no_ack_yet", 32'(reqAck), 32'h0);
    step();
    checkOutput("t3_ack", 32'(reqAck), 32'h2);
    checkOutput("t3_start", 32'(txStart), 32'h1);
    checkOutput("t3_gid", 32'(grantId), 32'h1);
    checkOutput("t3_data", 32'(txData), 32'(firstByte(1, 8'h31)));
    applyStimulus(4'b0000, 32'h0);
    waitIdle("t3_idle");

    $display("[TB] reset during frame");
    applyStimulus(4'b0100, 32'h00770000);
    step();
    checkOutput("t4_ack", 32'(reqAck), 32'h4);
    applyStimulus(4'b0000, 32'h0);
    for (int k = 0; k < 5; k++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("t4_rst_active", 32'(active), 32'h0);
    checkOutput("t4_rst_start", 32'(txStart), 32'h0);
    checkOutput("t4_rst_gid", 32'(grantId), 32'h0);
    checkOutput("t4_rst_data", 32'(txData), 32'h0);
    checkOutput("t4_rst_ack", 32'(reqAck), 32'h0);
    applyStimulus(4'b0101, 32'h00220020);
    waitAck("t4_wait_ack0");
    checkOutput("t4_ack0", 32'(reqAck), 32'h1);
    checkOutput("t4_gid0", 32'(grantId), 32'h0);
    checkOutput("t4_data0", 32'(txData), 32'(firstByte(0, 8'h20)));
    applyStimulus(4'b0100, 32'h00220000);
    step();
    waitAck("t4_wait_ack2");
    checkOutput("t4_ack2", 32'(reqAck), 32'h4);
    applyStimulus(4'b0000, 32'h0);
    waitIdle("t4_idle");

    $display("[TB] pointer wrap");
    applyStimulus(4'b0010, 32'h00005500);
    waitAck("t5_wait_ack1");
    applyStimulus(4'b0000, 32'h0);
    waitIdle("t5_idle1");
    applyStimulus(4'b1010, 32'h33005500);
    waitAck("t5_wait_ack3");
    checkOutput("t5_ack3", 32'(reqAck), 32'h8);
    checkOutput("t5_gid3", 32'(grantId), 32'h3);
    applyStimulus(4'b0010, 32'h00005500);
    step();
    waitAck("t5_wait_ack1b");
    checkOutput("t5_ack1", 32'(reqAck), 32'h2);
    applyStimulus(4'b0000, 32'h0);
    waitIdle("t5_idle2");

    reqValid3 = 3'b010;
    reqData3  = 24'h030201;
    waitAck3("t5n3_wait1");
    checkOutput("t5n3_ack1", 32'(reqAck3), 32'h2);
    reqValid3 = 3'b000;
    waitIdle3("t5n3_idle1");
    reqValid3 = 3'b100;
    waitAck3("t5n3_wait2");
    checkOutput("t5n3_ack2", 32'(reqAck3), 32'h4);
    reqValid3 = 3'b000;
    waitIdle3("t5n3_idle2");
    reqValid3 = 3'b101;
    waitAck3("t5n3_wait0");
    checkOutput("t5n3_ack0", 32'(reqAck3), 32'h1);
    checkOutput("t5n3_gid0", 32'(grantId3), 32'h0);
    checkOutput("t5n3_data0", 32'(txData3), 32'(firstByte(0, 8'h01)));
    reqValid3 = 3'b000;
    waitIdle3("t5n3_idle0");

    $display("[TB] client 3 sends 0x11");
    capQ.delete();
    ackQ.delete();
    applyStimulus(4'b1000, 32'h11000000);
    waitAck("t6_wait_ack");
    applyStimulus(4'b0000, 32'h0);
    waitIdle("t6_idle");
    checkOutput("t6_frames", 32'(capQ.size()), 32'(FRAMES));
    checkOutput("t6_data", 32'(capQ[capQ.size()-1]), 32'h11);
`ifdef UART_ARB_SRCID_EN
    checkOutput("t6_hdr", 32'(capQ[0]), 32'hA3);
`endif
    checkOutput("t6_ack_count", 32'(ackQ.size()), 32'd1);
    checkOutput("t6_ack", 32'(ackQ[0]), 32'h8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
